fsm_counter_sequencer: RTL and testbench

//   Sequencer that drives the enable of a CNT_W-bit FSM counter. Accepts a command
//   (step count N, prescale divide D) over valid/ready, then issues exactly N single-cycle
//   cnt_en pulses, one every D+1 cycles. Supports pause and abort, and reports completion.

---
 rtl/fsm_counter_sequencer.sv | 147 ++++++++++++++
 tb/tb_fsm_counter_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_counter_sequencer.sv
// Sequencer for a counter enable: issues N cnt_en pulses spaced D+1 cycles apart,
// with pause/abort and a done pulse. Define SEQ_WRAP_DETECT_EN to count counter wraps.
`timescale 1ns/1ps

module fsm_counter_sequencer #(
   parameter int STEP_W = 8,
   parameter int DIV_W  = 4,
   parameter int CNT_W  = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [STEP_W-1:0] cmd_steps,
   input  logic [DIV_W-1:0]  cmd_div,
   input  logic              pause,
   input  logic              abort,
   input  logic [CNT_W-1:0]  num,
   output logic              cnt_en,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic [STEP_W-1:0] steps_left,
   output logic [STEP_W-1:0] wraps,
   output logic [1:0]        state_dbg
);

   // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
   // cmd_ready depends on state only, so cmd_valid may be held across busy cycles.

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);
   localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);

   state_e             state_q, state_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
   logic [STEP_W-1:0]  steps_q, steps_d;
   logic               aborted_q, aborted_d;
   logic               accept;
   logic               pulse;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         div_q     <= '0;
         div_cnt_q <= '0;
         steps_q   <= '0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         div_cnt_q <= div_cnt_d;
         steps_q   <= steps_d;
         aborted_q <= aborted_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      div_cnt_d = div_cnt_q;
      steps_d   = steps_q;
      aborted_d = aborted_q;
      accept    = 1'b0;
      // Pulse depends only on registered state plus pause, never on abort.
      pulse     = (state_q == S_RUN) && !pause && (div_cnt_q == div_q);

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               accept    = 1'b1;
               div_d     = cmd_div;
               steps_d   = cmd_steps;
               div_cnt_d = '0;
               aborted_d = 1'b0;
               state_d   = (cmd_steps != '0) ? S_RUN : S_DONE;
            end
         end
         S_RUN: begin
            if (!pause) begin
               div_cnt_d = (div_cnt_q == div_q) ? '0 : div_cnt_q + DIV_ONE;
            end
            if (pulse && (steps_q != '0)) begin
               steps_d = steps_q - STEP_ONE;
            end
            if (abort) begin
               aborted_d = 1'b1;
               state_d   = S_DONE;
            end else if (pulse && (steps_q == STEP_ONE)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

`ifdef SEQ_WRAP_DETECT_EN
   logic [STEP_W-1:0] wraps_q, wraps_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wraps_q <= '0;
      end else begin
         wraps_q <= wraps_d;
      end
   end

   // A pulse while the counter shows all-ones means it rolls over to zero.
   always_comb begin
      wraps_d = wraps_q;
      if (accept) begin
         wraps_d = '0;
      end else if (pulse && (num == '1) && (wraps_q != '1)) begin
         wraps_d = wraps_q + STEP_ONE;
      end
   end

   assign wraps = wraps_q;
`else
   logic unused_num;
   logic unused_accept;

   assign unused_num    = ^num;
   assign unused_accept = accept;
   assign wraps         = '0;
`endif

   assign cnt_en     = pulse;
   assign cmd_ready  = (state_q == S_IDLE);
   assign busy       = (state_q == S_RUN);
   assign done       = (state_q == S_DONE);
   assign aborted    = aborted_q;
   assign steps_left = steps_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_fsm_counter_sequencer.sv
// Self-checking bench for fsm_counter_sequencer: directed scenarios plus randomized runs
// compared cycle by cycle against a pulse-schedule model.
`timescale 1ns/1ps

module tb_fsm_counter_sequencer;

   localparam int STEP_W = 8;
   localparam int DIV_W  = 4;
   localparam int CNT_W  = 3;

   logic              clk;
   logic              reset_n;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [STEP_W-1:0] cmd_steps;
   logic [DIV_W-1:0]  cmd_div;
   logic              pause;
   logic              abort;
   logic [CNT_W-1:0]  cnt_val;
   logic              cnt_clr;
   logic              cnt_en;
   logic              busy;
   logic              done;
   logic              aborted;
   logic [STEP_W-1:0] steps_left;
   logic [STEP_W-1:0] wraps;
   logic [1:0]        state_dbg;

   int n_checks = 0;
   int n_fail   = 0;

   fsm_counter_sequencer #(.STEP_W(STEP_W), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_steps  (cmd_steps),
      .cmd_div    (cmd_div),
      .pause      (pause),
      .abort      (abort),
      .num        (cnt_val),
      .cnt_en     (cnt_en),
      .busy       (busy),
      .done       (done),
      .aborted    (aborted),
      .steps_left (steps_left),
      .wraps      (wraps),
      .state_dbg  (state_dbg)
   );

   // Clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counter fed back on num, driven by the DUT's enable.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     cnt_val <= '0;
      else if (cnt_clr) cnt_val <= '0;
      else if (cnt_en)  cnt_val <= cnt_val + CNT_W'(1);
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Wraps seen after `pulses` enables from a counter that started at 0.
   function automatic int exp_wraps(input int pulses);
`ifdef SEQ_WRAP_DETECT_EN
      int w;
      w = pulses / (1 << CNT_W);
      return (w > 255) ? 255 : w;
`else
      return 0;
`endif
   endfunction

   // Driver + model: issue one command, then check every cycle against the schedule
   // "pulse on every (D+1)-th unpaused cycle, stop after N pulses or on abort".
   task automatic run_cmd(input int n, input int d, input int plo, input int phi,
                          input bit rnd_pause, input int abort_c, input bit abort_acc,
                          output int done_c);
      int   m_active;
      int   m_pulses;
      int   phase;
      int   c;
      bit   m_ab;
      logic p;
      logic en_e;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_steps = STEP_W'(n);
      cmd_div   = DIV_W'(d);
      pause     = 1'b0;
      abort     = abort_acc;
      cnt_clr   = 1'b1;
      #1 chk("accept_ready", 32'(cmd_ready), 32'd1);
      @(posedge clk);
      #1;
      cnt_clr   = 1'b0;
      cmd_valid = 1'b0;
      abort     = 1'b0;
      m_active  = 0;
      m_pulses  = 0;
      m_ab      = 1'b0;
      phase     = (n == 0) ? 1 : 0;
      done_c    = -1;
      c         = 0;
      while (phase != 2 && c < 4000) begin
         c++;
         @(negedge clk);
         p = (phase == 0) && ((c >= plo && c <= phi) ||
                              (rnd_pause && ($urandom_range(0, 3) == 0)));
         pause     = p;
         abort     = (c == abort_c);
         cmd_valid = (phase == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
         cmd_steps = STEP_W'($urandom);
         cmd_div   = DIV_W'($urandom);
         #1;
         if (phase == 0) begin
            en_e = 1'b0;
            if (!p) begin
               m_active++;
               en_e = ((m_active % (d + 1)) == 0);
            end
            chk("run_cnt_en", 32'(cnt_en), 32'(en_e));
            chk("run_busy", 32'(busy), 32'd1);
            chk("run_done", 32'(done), 32'd0);
            chk("run_ready", 32'(cmd_ready), 32'd0);
            chk("run_steps", 32'(steps_left), 32'(n - m_pulses));
            chk("run_wraps", 32'(wraps), 32'(exp_wraps(m_pulses)));
            if (en_e) m_pulses++;
            if (abort) begin
               m_ab  = 1'b1;
               phase = 1;
            end else if (m_pulses == n) begin
               phase = 1;
            end
         end else begin
            chk("done_pulse", 32'(done), 32'd1);
            chk("done_busy", 32'(busy), 32'd0);
            chk("done_cnt_en", 32'(cnt_en), 32'd0);
            chk("done_ready", 32'(cmd_ready), 32'd0);
            chk("done_aborted", 32'(aborted), 32'(m_ab));
            chk("done_steps", 32'(steps_left), 32'(n - m_pulses));
            chk("done_wraps", 32'(wraps), 32'(exp_wraps(m_pulses)));
            done_c = c;
            phase  = 2;
         end
      end
      chk("run_bound", 32'(phase), 32'd2);
      // First idle cycle: ready again, results held, abort ignored.
      @(negedge clk);
      pause     = 1'b0;
      cmd_valid = 1'b0;
      abort     = 1'($urandom_range(0, 1));
      #1;
      chk("idle_ready", 32'(cmd_ready), 32'd1);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_aborted", 32'(aborted), 32'(m_ab));
      chk("idle_steps", 32'(steps_left), 32'(n - m_pulses));
      chk("idle_wraps", 32'(wraps), 32'(exp_wraps(m_pulses)));
      @(posedge clk);
      #1 abort = 1'b0;
   endtask

   initial begin
      int dc;
      int rn;
      int rd;
      int ra;
      reset_n   = 1'b0;
      cmd_valid = 1'b0;
      cmd_steps = '0;
      cmd_div   = '0;
      pause     = 1'b0;
      abort     = 1'b0;
      cnt_clr   = 1'b0;
      #12;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_steps", 32'(steps_left), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1 chk("rst_ready", 32'(cmd_ready), 32'd1);

      // Reset mid-run: N=10, D=2, reset while the first pulse is high.
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_steps = STEP_W'(10);
      cmd_div   = DIV_W'(2);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      #1 chk("mid_cnt_en", 32'(cnt_en), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_cnt_en", 32'(cnt_en), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_aborted", 32'(aborted), 32'd0);
      chk("mid_rst_steps", 32'(steps_left), 32'd0);
      chk("mid_rst_wraps", 32'(wraps), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("mid_rel_ready", 32'(cmd_ready), 32'd1);
      chk("mid_rel_done", 32'(done), 32'd0);

      run_cmd(4, 0, 0, -1, 1'b0, -1, 1'b0, dc);
      chk("n4_d0_done_cycle", 32'(dc), 32'd5);
      run_cmd(3, 2, 0, -1, 1'b0, -1, 1'b0, dc);
      chk("n3_d2_done_cycle", 32'(dc), 32'd10);
      run_cmd(5, 1, 3, 6, 1'b0, -1, 1'b0, dc);
      chk("n5_pause_done_cycle", 32'(dc), 32'd15);
      run_cmd(8, 0, 0, -1, 1'b0, 3, 1'b0, dc);
      chk("n8_abort_done_cycle", 32'(dc), 32'd4);
      chk("n8_abort_steps", 32'(steps_left), 32'd5);
      chk("n8_abort_flag", 32'(aborted), 32'd1);
      run_cmd(0, 3, 0, -1, 1'b0, -1, 1'b0, dc);
      chk("n0_done_cycle", 32'(dc), 32'd1);
      chk("n0_aborted_cleared", 32'(aborted), 32'd0);
      run_cmd(16, 0, 0, -1, 1'b0, -1, 1'b0, dc);
      chk("n16_done_cycle", 32'(dc), 32'd17);
`ifdef SEQ_WRAP_DETECT_EN
      chk("n16_wraps", 32'(wraps), 32'd2);
`else
      chk("n16_wraps", 32'(wraps), 32'd0);
`endif
      run_cmd(6, 1, 0, -1, 1'b0, -1, 1'b1, dc);
      chk("abort_at_accept_done_cycle", 32'(dc), 32'd13);
      run_cmd(2, 0, 0, -1, 1'b0, 2, 1'b0, dc);
      chk("abort_last_pulse_aborted", 32'(aborted), 32'd1);
      chk("abort_last_pulse_steps", 32'(steps_left), 32'd0);

      for (int i = 0; i < 25; i++) begin
         rn = $urandom_range(0, 20);
         rd = $urandom_range(0, 3);
         ra = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 60) : -1;
         run_cmd(rn, rd, 0, -1, 1'b1, ra, 1'($urandom_range(0, 1)), dc);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
